// File: rtl/inst_fetch_seq_pkg.sv
// Shared types for the instruction fetch sequencer: sequencer states and
// branch-condition encodings used by the decoder and the PC mux.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    localparam logic [1:0] BR_ALWAYS = 2'b00;
    localparam logic [1:0] BR_ZERO   = 2'b01;
    localparam logic [1:0] BR_NZERO  = 2'b10;
    localparam logic [1:0] BR_NEVER  = 2'b11;

    function automatic logic br_taken(input logic [1:0] cond, input logic alu_zero);
        logic taken;
        taken = 1'b0;
        case (cond)
            BR_ALWAYS: taken = 1'b1;
            BR_ZERO:   taken = alu_zero;
            BR_NZERO:  taken = !alu_zero;
            BR_NEVER:  taken = 1'b0;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/inst_fetch_seq_if.sv
// Control/flag inputs from the decoder and ALU, plus the fetch address and
// status outputs towards instruction memory.
interface inst_fetch_seq_if #(
    parameter int PC_W = 11
);
    logic            Start;
    logic            Halt;
    logic            Stall;
    logic            Branch;
    logic [1:0]      BrCond;
    logic            BrRel;
    logic            AluZero;
    logic            Call;
    logic            Ret;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic            Running;
    logic            Done;
    logic            Fault;

    modport master (
        output Start, Halt, Stall, Branch, BrCond, BrRel, AluZero, Call, Ret, Target,
        input  ProgCtr, Running, Done, Fault
    );

    modport slave (
        input  Start, Halt, Stall, Branch, BrCond, BrRel, AluZero, Call, Ret, Target,
        output ProgCtr, Running, Done, Fault
    );
endinterface

// File: rtl/inst_fetch_seq_ret_stack.sv
// Return-address LIFO. The pointer is one bit wider than the index so that
// full (pointer == depth) and empty (pointer == 0) are distinct.
module ret_stack #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       sp_q;
    logic [AW:0]       top_idx;

    assign full_o  = (sp_q == (AW+1)'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_idx = sp_q - (AW+1)'(1);
    assign dout_o  = mem_q[top_idx[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (clr_i) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + (AW+1)'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - (AW+1)'(1);
        end
    end

    // Entry storage carries no reset; only entries below the pointer are ever read.
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clr_i) begin
            mem_q[sp_q[AW-1:0]] <= din_i;
        end
    end
endmodule

// File: rtl/inst_fetch_seq.sv
// Program-counter sequencer: IDLE/RUN/HALT control, stall, conditional and
// relative branches, and call/return through a fault-checked stack.
module inst_fetch_seq
    import inst_fetch_pkg::*;
#(
    parameter int              PC_W        = 11,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] START_ADDR  = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    inst_fetch_seq_if.slave bus
);
    state_e                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic                   fault_q, fault_d;
    logic                   push, pop, clr;
    logic [PC_W-1:0]        stk_dout;
    logic                   stk_full, stk_empty;
    logic [PC_W-1:0]        pc_inc;
    logic signed [PC_W-1:0] pc_rel;

    assign pc_inc = pc_q + PC_W'(1);
    // Relative targets are two's-complement offsets; the sum wraps mod 2^PC_W.
    assign pc_rel = $signed(pc_q) + $signed(bus.Target);

    ret_stack #(
        .DATA_W (PC_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk     (Clk),
        .rst_n   (Reset),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (pc_inc),
        .dout_o  (stk_dout),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = START_ADDR;
                if (bus.Start) state_d = RUN;
            end
            RUN: begin
                if (bus.Halt) begin
                    state_d = HALT;
                end else if (bus.Stall) begin
                    pc_d = pc_q;
                end else if (bus.Ret) begin
                    if (stk_empty) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_dout;
                    end
                end else if (bus.Call) begin
                    if (stk_full) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        push = 1'b1;
                        pc_d = bus.Target;
                    end
                end else if (bus.Branch && br_taken(bus.BrCond, bus.AluZero)) begin
                    pc_d = bus.BrRel ? $unsigned(pc_rel) : bus.Target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALT: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    assign bus.ProgCtr = pc_q;
    assign bus.Running = (state_q == RUN);
    assign bus.Done    = (state_q == HALT);
    assign bus.Fault   = fault_q;
endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_inst_fetch_seq;
    import inst_fetch_pkg::*;

    localparam int PC_W  = 11;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << PC_W;

    logic Clk;
    logic Reset;
    inst_fetch_seq_if #(.PC_W(PC_W)) bus ();

    inst_fetch_seq #(
        .PC_W        (PC_W),
        .STACK_DEPTH (DEPTH),
        .START_ADDR  ('0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit       st, hl, sl, br;
        bit [1:0] cd;
        bit       rl, zr, cl, rt;
        int       tg;
        int       pc;
        bit       run, dn, ft;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    bit          m_run, m_halt, m_fault;
    int unsigned m_pc;
    int unsigned m_stk[$];

    function automatic vec_t mk(input bit st, hl, sl, br, input bit [1:0] cd,
                                input bit rl, zr, cl, rt, input int tg,
                                input int pc, input bit run, dn, ft);
        vec_t v;
        v.st = st; v.hl = hl; v.sl = sl; v.br = br; v.cd = cd;
        v.rl = rl; v.zr = zr; v.cl = cl; v.rt = rt; v.tg = tg;
        v.pc = pc; v.run = run; v.dn = dn; v.ft = ft;
        return v;
    endfunction

    function automatic vec_t none(input int pc);
        return mk(0,0,0,0,2'b00,0,0,0,0,0, pc,1,0,0);
    endfunction

    task automatic apply(input vec_t v);
        bus.Start   = v.st;
        bus.Halt    = v.hl;
        bus.Stall   = v.sl;
        bus.Branch  = v.br;
        bus.BrCond  = v.cd;
        bus.BrRel   = v.rl;
        bus.AluZero = v.zr;
        bus.Call    = v.cl;
        bus.Ret     = v.rt;
        bus.Target  = PC_W'(v.tg);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input int epc, input bit er, ed, ef);
        n_chk++;
        if (bus.ProgCtr !== PC_W'(epc) || bus.Running !== er || bus.Done !== ed || bus.Fault !== ef) begin
            n_fail++;
            $display("FAIL %s: got pc=%0d run=%b done=%b fault=%b, expected pc=%0d run=%b done=%b fault=%b",
                     nm, bus.ProgCtr, bus.Running, bus.Done, bus.Fault, epc, er, ed, ef);
        end
    endtask

    task automatic do_reset();
        apply(mk(0,0,0,0,2'b00,0,0,0,0,0, 0,0,0,0));
        Reset = 1'b0;
        tick();
        tick();
        chk("reset_state", 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        m_run = 0; m_halt = 0; m_fault = 0; m_pc = 0;
        m_stk.delete();
    endtask

    // Model: applies the fetch rules to one clock edge, in priority order.
    function automatic void model_edge(input vec_t v);
        bit taken;
        taken = (v.cd == BR_ALWAYS) || (v.cd == BR_ZERO && v.zr) || (v.cd == BR_NZERO && !v.zr);
        if (!m_run && !m_halt) begin
            m_pc = 0;
            if (v.st) m_run = 1;
        end else if (m_halt) begin
            if (v.st) begin
                m_halt = 0; m_run = 1; m_pc = 0;
                m_stk.delete();
            end
        end else if (v.hl) begin
            m_run = 0; m_halt = 1;
        end else if (v.sl) begin
            m_pc = m_pc;
        end else if (v.rt) begin
            if (m_stk.size() == 0) begin
                m_fault = 1; m_run = 0; m_halt = 1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (v.cl) begin
            if (m_stk.size() == DEPTH) begin
                m_fault = 1; m_run = 0; m_halt = 1;
            end else begin
                m_stk.push_back((m_pc + 1) % MOD);
                m_pc = v.tg % MOD;
            end
        end else if (v.br && taken) begin
            m_pc = v.rl ? (m_pc + v.tg) % MOD : v.tg % MOD;
        end else begin
            m_pc = (m_pc + 1) % MOD;
        end
    endfunction

    initial begin
        vec_t v;
        Reset = 1'b0;
        apply(mk(0,0,0,0,2'b00,0,0,0,0,0, 0,0,0,0));

        // Directed vector table: {inputs, expected ProgCtr/Running/Done/Fault}
        vecs.push_back(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,1,0,0));
        for (int i = 1; i <= 10; i++) vecs.push_back(none(i));
        vecs.push_back(mk(0,0,0,1,BR_ZERO,1,1,0,0,'h7FD, 7,1,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1,0,BR_ALWAYS,0,0,0,0,0, 7,1,0,0));
        vecs.push_back(none(8));
        vecs.push_back(none(9));
        vecs.push_back(none(10));
        vecs.push_back(mk(0,0,0,1,BR_ZERO,1,0,0,0,'h7FD, 11,1,0,0));
        vecs.push_back(mk(0,0,0,1,BR_ALWAYS,0,0,0,0,10, 10,1,0,0));
        vecs.push_back(mk(0,0,0,1,BR_ALWAYS,0,0,0,0,500, 500,1,0,0));
        vecs.push_back(mk(0,0,0,1,BR_NEVER,0,1,0,0,5, 501,1,0,0));
        vecs.push_back(mk(0,0,0,1,BR_NZERO,0,0,0,0,20, 20,1,0,0));
        vecs.push_back(mk(0,0,0,0,BR_ALWAYS,0,0,1,0,100, 100,1,0,0));
        vecs.push_back(none(101));
        vecs.push_back(none(102));
        vecs.push_back(none(103));
        vecs.push_back(mk(0,0,0,0,BR_ALWAYS,0,0,0,1,0, 21,1,0,0));
        vecs.push_back(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 22,1,0,0));
        vecs.push_back(mk(0,0,0,1,BR_ALWAYS,0,0,0,0,2046, 2046,1,0,0));
        vecs.push_back(none(2047));
        vecs.push_back(none(0));
        vecs.push_back(mk(0,0,0,1,BR_ALWAYS,0,0,0,0,2047, 2047,1,0,0));
        vecs.push_back(mk(0,0,0,0,BR_ALWAYS,0,0,1,0,5, 5,1,0,0));
        vecs.push_back(mk(0,0,0,0,BR_ALWAYS,0,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk(0,1,0,1,BR_ALWAYS,0,0,0,0,300, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,1,0,0));
        vecs.push_back(none(1));

        // Counting from Start: 0,0,1..19
        do_reset();
        apply(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,1,0,0));
        tick();
        chk("start_first_fetch", 0, 1, 0, 0);
        apply(none(0));
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk($sformatf("count_%0d", i), i, 1, 0, 0);
        end

        // Table
        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i]);
            tick();
            chk($sformatf("vec_%0d", i), vecs[i].pc, vecs[i].run, vecs[i].dn, vecs[i].ft);
        end

        // Stack overflow on the fifth nested call
        do_reset();
        apply(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,0,0,0));
        tick();
        for (int i = 1; i <= 4; i++) begin
            apply(mk(0,0,0,0,BR_ALWAYS,0,0,1,0,10*i, 0,0,0,0));
            tick();
            chk($sformatf("nest_call_%0d", i), 10*i, 1, 0, 0);
        end
        apply(mk(0,0,0,0,BR_ALWAYS,0,0,1,0,50, 0,0,0,0));
        tick();
        chk("overflow_fault", 40, 0, 1, 1);
        apply(none(0));
        tick();
        chk("overflow_held", 40, 0, 1, 1);

        // Restart from HALT keeps Fault and empties the stack
        apply(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,0,0,0));
        tick();
        chk("restart_after_fault", 0, 1, 0, 1);
        apply(none(0));
        tick();
        chk("run_with_fault", 1, 1, 0, 1);
        apply(mk(0,0,0,0,BR_ALWAYS,0,0,0,1,0, 0,0,0,0));
        tick();
        chk("ret_after_restart_empty", 1, 0, 1, 1);
        apply(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,0,0,0));
        tick();
        apply(none(0));
        tick();
        tick();

        // Asynchronous reset between edges
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("async_reset_mid_run", 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Underflow on a fresh program
        apply(mk(1,0,0,0,BR_ALWAYS,0,0,0,0,0, 0,0,0,0));
        tick();
        apply(mk(0,0,0,0,BR_ALWAYS,0,0,0,1,0, 0,0,0,0));
        tick();
        chk("underflow_fault", 0, 0, 1, 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v.st = ($urandom_range(3) == 0);
            v.hl = ($urandom_range(63) == 0);
            v.sl = ($urandom_range(7) == 0);
            v.rt = ($urandom_range(9) == 0);
            v.cl = ($urandom_range(9) == 0);
            v.br = ($urandom_range(3) == 0);
            v.cd = 2'($urandom_range(3));
            v.rl = 1'($urandom_range(1));
            v.zr = 1'($urandom_range(1));
            v.tg = int'($urandom_range(MOD-1));
            v.pc = 0; v.run = 0; v.dn = 0; v.ft = 0;
            apply(v);
            tick();
            model_edge(v);
            chk($sformatf("rand_%0d", i), int'(m_pc), m_run, m_halt, m_fault);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_seq.md
Name: inst_fetch_seq

Overview:
Parametrised successor to the single-width fetch unit. Generates the program counter for the instruction ROM. Adds the following over the previous generation:
- explicit IDLE/RUN/HALT sequencing
- stall
- conditional-branch modes: always / zero / nonzero
- absolute or PC-relative targets
- a call/return stack of configurable depth with fault detection

Sits between the control decoder/ALU flags and the instruction memory address port.

Parameters:
PC_W, 11, program counter and target width in bits
STACK_DEPTH, 4, call/return stack entries (power of two, >=2)
START_ADDR, 0, PC value loaded on reset and on every Start

Ports:
Clk  in  1  clock; all state updates on posedge
Reset  in  1  asynchronous, active-low reset
Start  in  1  begin program at START_ADDR (sampled in IDLE/HALT)
Halt  in  1  stop fetching after current cycle
Stall  in  1  hold PC and stack this cycle (RUN only)
Branch  in  1  branch request
BrCond  in  2  00 always, 01 if AluZero, 10 if !AluZero, 11 never
BrRel  in  1  1: PC-relative (Target signed), 0: absolute
AluZero  in  1  zero flag from ALU
Call  in  1  push return address, jump absolute to Target
Ret  in  1  pop stack into PC
Target  in  PC_W  branch/call target or signed offset
ProgCtr  out  PC_W  current fetch address
Running  out  1  high in RUN
Done  out  1  high in HALT
Fault  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset low (async):
  - ProgCtr=START_ADDR, state IDLE, stack pointer 0.
  - Running=0, Done=0, Fault=0.
  - Reset mid-operation discards all state immediately.
- IDLE:
  - ProgCtr holds START_ADDR.
  - Start=1 at posedge -> RUN; ProgCtr unchanged, so the first RUN cycle fetches START_ADDR.
- RUN, per posedge, first match wins:
  1. Halt -> HALT, PC held.
  2. Stall -> PC and stack held.
  3. Ret -> pop. Empty stack -> Fault=1, HALT, PC held.
  4. Call -> push PC+1, PC=Target. Full stack -> Fault=1, HALT, PC held, no push.
  5. Branch with condition true:
     - BrRel=1: PC = PC + Target, two's complement, mod 2^PC_W.
     - BrRel=0: PC = Target.
  6. Otherwise PC = PC+1 mod 2^PC_W; 2^PC_W-1 wraps to 0.
- Start is ignored in RUN.
- Branch with condition false (including BrCond=11) -> PC+1.
- HALT:
  - PC held, Done=1.
  - Start -> RUN with PC=START_ADDR, stack pointer 0; Fault retained.
- Fault is cleared only by Reset.
- Stack:
  - LIFO array of STACK_DEPTH x PC_W with pointer of clog2(STACK_DEPTH)+1 bits.
  - Push/pop take effect at the same posedge as the PC update.
  - Return address is registered PC+1, so a Call at 2^PC_W-1 returns to 0.
- Running and Done are decoded from the registered state; no combinational path from inputs to any output.
- Latency: every input affects ProgCtr on the next posedge.

Decomposition:
- Shared package inst_fetch_pkg holds:
  - state enum IDLE/RUN/HALT
  - BrCond encodings BR_ALWAYS, BR_ZERO, BR_NZERO, BR_NEVER
- Sub-module ret_stack (parametrised LIFO):
  - inputs: push, pop, din
  - outputs: dout, full, empty
- Sequencer and PC mux stay in inst_fetch_seq.

Test Plan:
- Reset low then high, Start pulse, no controls for 20 cycles -> ProgCtr 0,0,1,2...19; Running=1, Done=0.
- PC at 2046 (PC_W=11), no branch -> 2047 then 0 (wrap).
- PC=10:
  - Branch, BrCond=01, AluZero=1, BrRel=1, Target=0x7FD (-3) -> PC=7.
  - Same with AluZero=0 -> PC=11.
  - BrCond=00, BrRel=0, Target=500 -> PC=500.
- Call at PC=20 with Target=100 -> PC=100; advance to 103, Ret -> PC=21.
- Depth test:
  - 5 nested Calls, STACK_DEPTH=4 -> Fault=1, Done=1, PC held at fifth call site.
  - Ret on empty after fresh Start -> Fault=1, HALT.
- Stall held 3 cycles at PC=7 -> PC stays 7, then 8.
- Halt+Branch same cycle -> HALT, PC held; Start -> PC=0, Running=1.
- Reset dropped mid-RUN between clock edges -> ProgCtr=0, outputs cleared before next posedge.
